dram_cmd_arbiter: RTL and testbench
===================================

# dram_cmd_arbiter

Multi-requester front end for the DRAM memory controller's command port. It takes 34-bit access commands plus write data from `NUM_REQ` independent requesters and arbitrates among them round-robin. It issues only commands whose target bank currently has its `ba_cmd_pm` permit bit set. An in-order read-tag FIFO routes each returned `read_data` beat back to the requester that issued the read.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DQ_BITS`, 16, DRAM DQ width; data bus is `DQ_BITS*8` bits
- `TAG_DEPTH`, 16, read-tag FIFO depth (power of 2)

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `power_on_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: requester i has a command pending.
- `req_command` in `NUM_REQ*34`: slice i = {rank[33:32], rw[31] (0=write, 1=read), 0, row[29:17], 0, bl[15], 0, auto_pre[13], col[12:3], bank[2:0]}.
- `req_wdata` in `NUM_REQ*DQ_BITS*8`: write data for requester i; ignored on reads.
- `req_ready` out `NUM_REQ`: one-hot grant; accepted when `req_valid[i] & req_ready[i]`.
- `command` out 34: command to controller.
- `valid` out 1: `command` is valid this cycle.
- `write_data` out `DQ_BITS*8`: write data paired with `command`; 0 for reads.
- `ba_cmd_pm` in 8: per-bank permit from controller; bit b set means bank b accepts a command.
- `read_data` in `DQ_BITS*8`: read data from controller. Returned in issue order.
- `read_data_valid` in 1: `read_data` is valid.
- `rsp_valid` out `NUM_REQ`: one-hot; read data for requester i.
- `rsp_data` out `DQ_BITS*8`: read data, shared by all requesters.
- `rd_outstanding` out `$clog2(TAG_DEPTH)+1`: reads issued and not yet returned.
- `err_unexpected_rdata` out 1: sticky flag; set when read data arrives with no read outstanding.

## Operation
- **Eligibility.** Requester i is eligible when all of the following hold:
  - `req_valid[i]` is high.
  - `ba_cmd_pm[bank_i]` is high.
  - Either `rw_i`=0, or the tag FIFO is not full.
- **Grant.** Combinational, round-robin. Search starts at pointer `rr_ptr` and ascends with wrap. The first eligible requester gets `req_ready`=1. At most one `req_ready` bit is high per cycle.
- **Pointer update.** On an accepted grant to requester g, `rr_ptr` ← (g+1) mod `NUM_REQ`. With no grant, `rr_ptr` holds.
- **Issue.** The accepted command is registered to `command`, `valid`=1 and `write_data` (write: `req_wdata` slice; read: 0) on the same edge.
  - In a cycle with no accept, the next edge drives `valid`=0 and `command`=0. `write_data` holds.
- **Read tags.**
  - Each accepted read pushes requester index g into the tag FIFO.
  - Each `read_data_valid`=1 pops the FIFO head h. The next edge registers `rsp_valid`=one-hot(h) and `rsp_data`=`read_data`.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- **Empty FIFO.** `read_data_valid` with the FIFO empty causes no pop and `rsp_valid`=0, and sets `err_unexpected_rdata`. The flag clears only on reset.
- **Full FIFO.**
  - When full, reads are ineligible; writes still arbitrate.
  - If a pop and a read request coincide while full, the read is still blocked: full is evaluated on registered occupancy.
- **Counter.** `rd_outstanding` equals FIFO occupancy and ranges 0..`TAG_DEPTH`.
- **Permit changes.** A `ba_cmd_pm` change takes effect in the same cycle. No request is held speculatively; requesters keep `req_valid` and a stable command until accepted.

## Timing
- **Reset values:**
  - `valid`=0, `command`=0, `write_data`=0
  - `rsp_valid`=0, `rsp_data`=0
  - `rd_outstanding`=0, `err_unexpected_rdata`=0
  - `rr_ptr`=0, tag FIFO empty
  - `req_ready` is combinational and therefore 0 while all `req_valid`=0.
- **Reset mid-operation.** All state clears immediately. Outstanding reads are forgotten; data returning after reset raises `err_unexpected_rdata`.
- **Latencies.**
  - Accept at edge N puts `valid`/`command` on the bus from N until N+1. Latency is 1 cycle.
  - Back-to-back issue is allowed at one command per cycle.
  - `read_data_valid` at edge M gives `rsp_valid` during M..M+1. Latency is 1 cycle.
- **Controller interface.** The controller samples `command` on the edge after `valid` rises. `ba_cmd_pm` is sampled combinationally in the grant cycle only.

## Test plan
- **Single write.** Reset, then requester 0 writes (row 5, col 8, bank 2) with `ba_cmd_pm`=8'hFF. Required: `req_ready[0]`=1 for one cycle; next cycle `valid`=1, `command[31]`=0, `command[2:0]`=2, `write_data` equal to the request data; `rd_outstanding`=0.
- **Round-robin fairness.** All 4 requesters hold write requests to bank 0 with permit=1. Required: grants in order 0,1,2,3,0 on consecutive cycles; `valid` high continuously.
- **Permit blocking.** Requester 1 targets bank 3, requester 2 targets bank 1; `ba_cmd_pm`=8'h02. Required: only requester 2 is granted. After `ba_cmd_pm`=8'h08, requester 1 is granted the same cycle.
- **Read routing.**
  - Stimulus: reads issued by requesters 3, 0, 2 in that order; controller then returns three beats 0xA, 0xB, 0xC.
  - Required: `rsp_valid`=4'b1000 with `rsp_data`=0xA, then 4'b0001 with 0xB, then 4'b0100 with 0xC; `rd_outstanding` goes 3→0.
- **Full FIFO.** Issue 16 reads with no return. Required: `rd_outstanding`=16 and further reads are stalled while writes are still granted. One `read_data_valid` lets the next read issue one cycle later.
- **Unexpected data and reset.** `read_data_valid` with no read outstanding gives `err_unexpected_rdata`=1 and `rsp_valid`=0. Asserting `power_on_rst_n`=0 mid-burst gives all outputs 0 immediately.

Source files
------------

// File: rtl/dram_cmd_arbiter_if.sv
// Purpose: bundles the requester, controller-command and read-return buses of dram_cmd_arbiter.
// Latency: none (wires only).
// Backpressure: req_ready grants one requester per cycle; ba_cmd_pm and tag-FIFO space gate the grant.
//
// Modports:
//   slave  - the arbiter's view: requests, permits and read data in; grants, command, responses out.
//   master - the requesters'/controller's view, the mirror of slave.
interface dram_cmd_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DQ_BITS   = 16,
    parameter int TAG_DEPTH = 16
);
    localparam int DW = DQ_BITS * 8;
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*34-1:0] req_command;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [33:0]           command;
    logic                  valid;
    logic [DW-1:0]         write_data;
    logic [7:0]            ba_cmd_pm;
    logic [DW-1:0]         read_data;
    logic                  read_data_valid;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic [CW-1:0]         rd_outstanding;
    logic                  err_unexpected_rdata;

    modport slave (
        input  req_valid, req_command, req_wdata, ba_cmd_pm, read_data, read_data_valid,
        output req_ready, command, valid, write_data, rsp_valid, rsp_data,
               rd_outstanding, err_unexpected_rdata
    );

    modport master (
        output req_valid, req_command, req_wdata, ba_cmd_pm, read_data, read_data_valid,
        input  req_ready, command, valid, write_data, rsp_valid, rsp_data,
               rd_outstanding, err_unexpected_rdata
    );
endinterface

// File: rtl/dram_cmd_arbiter.sv
// Purpose: round-robin arbiter feeding the DRAM controller command port, with read-tag return routing.
// Latency: 1 cycle from accept to command/valid; 1 cycle from read_data_valid to rsp_valid.
// Backpressure: a requester is granted only if its bank permit is set and, for reads, the tag FIFO has room.
//
// Ports: clk, power_on_rst_n (async active-low); bus (dram_cmd_arbiter_if.slave) carries
// requests/grants, the registered command + write data, bank permits, read data in and routed responses.

// Generic synchronous FIFO: push ignored when full, pop ignored when empty.
// Latency: pop_dat shows the head combinationally; count updates on the clock edge.
// Backpressure: caller must watch full/empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module dram_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DQ_BITS   = 16,
    parameter int TAG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              power_on_rst_n,
    dram_cmd_arbiter_if.slave bus
);
    localparam int DW = DQ_BITS * 8;
    localparam int RW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TAG_DEPTH) + 1;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant;
    logic [RW-1:0]      grant_idx;
    logic [RW-1:0]      rr_ptr;
    logic               accept;
    logic [33:0]        sel_cmd;
    logic [DW-1:0]      sel_wdata;

    logic               tag_full;
    logic               tag_empty;
    logic [RW-1:0]      tag_head;
    logic [CW-1:0]      tag_count;
    logic               tag_pop;

    logic [33:0]        command_q;
    logic               valid_q;
    logic [DW-1:0]      write_data_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [DW-1:0]      rsp_data_q;
    logic               err_q;

    // Permit and FIFO-full are both looked at in the grant cycle; full comes from
    // registered occupancy so a same-cycle pop does not free a slot early.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i]
                    & bus.ba_cmd_pm[bus.req_command[i*34 +: 3]]
                    & (~bus.req_command[i*34 + 31] | ~tag_full);
        end
    end

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        int            s;
        logic [RW-1:0] idx;
        logic          found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        s         = 0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = RW'(s);
            if (!found && elig[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    // No grants while reset is held, so nothing is accepted that the reset would drop.
    assign bus.req_ready = grant & {NUM_REQ{power_on_rst_n}};
    assign accept        = |bus.req_ready;

    // One-hot grant makes an OR-mux sufficient.
    always_comb begin
        sel_cmd   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_cmd   = sel_cmd   | bus.req_command[i*34 +: 34];
                sel_wdata = sel_wdata | bus.req_wdata[i*DW +: DW];
            end
        end
    end

    assign tag_pop = bus.read_data_valid & ~tag_empty;

    // Read tags hold the requester index; data returns in issue order so the head owns each beat.
    fifo #(
        .WIDTH (RW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .core_clk (clk),
        .arst_n   (power_on_rst_n),
        .push_vld (accept & sel_cmd[31]),
        .push_dat (grant_idx),
        .pop_rdy  (bus.read_data_valid),
        .pop_dat  (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            rr_ptr       <= '0;
            command_q    <= '0;
            valid_q      <= 1'b0;
            write_data_q <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            valid_q   <= accept;
            command_q <= accept ? sel_cmd : 34'd0;
            // write_data deliberately holds across idle cycles.
            if (accept) begin
                write_data_q <= sel_cmd[31] ? '0 : sel_wdata;
                rr_ptr       <= (grant_idx == RW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            rsp_valid_q <= '0;
            if (tag_pop) begin
                rsp_valid_q[tag_head] <= 1'b1;
                rsp_data_q            <= bus.read_data;
            end
            if (bus.read_data_valid && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.command              = command_q;
    assign bus.valid                = valid_q;
    assign bus.write_data           = write_data_q;
    assign bus.rsp_valid            = rsp_valid_q;
    assign bus.rsp_data             = rsp_data_q;
    assign bus.rd_outstanding       = tag_count;
    assign bus.err_unexpected_rdata = err_q;
endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// Purpose: directed self-checking bench for dram_cmd_arbiter.
// Latency: inputs change 1 time unit after a rising edge; outputs are compared away from the edge.
// Backpressure: requesters drop req_valid on the cycle after their accept.
module tb_dram_cmd_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DQ_BITS   = 16;
    localparam int TAG_DEPTH = 16;
    localparam int DW        = DQ_BITS * 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dram_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .DQ_BITS(DQ_BITS), .TAG_DEPTH(TAG_DEPTH)) bus ();

    dram_cmd_arbiter #(.NUM_REQ(NUM_REQ), .DQ_BITS(DQ_BITS), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk            (clk),
        .power_on_rst_n (rst_n),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [33:0] mk_cmd(input logic rw, input logic [12:0] row,
                                           input logic [9:0] col, input logic [2:0] bank);
        return {2'b00, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [33:0] c, input logic [DW-1:0] d);
        bus.req_valid[i]             = v;
        bus.req_command[i*34 +: 34]  = c;
        bus.req_wdata[i*DW +: DW]    = d;
    endtask

    task automatic clear_inputs();
        bus.req_valid       = '0;
        bus.req_command     = '0;
        bus.req_wdata       = '0;
        bus.ba_cmd_pm       = 8'hFF;
        bus.read_data       = '0;
        bus.read_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [33:0]   rr_cmd [NUM_REQ];
        logic [DW-1:0] rr_wd  [NUM_REQ];
        logic [3:0]    oh;
        logic [33:0]   c1;
        logic [33:0]   c2;
        logic [DW-1:0] rd_beat [3];
        int            rd_req  [3];

        // Reset state
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid",      bus.valid, 1'b0);
        chk("rst_command",    bus.command, 34'd0);
        chk("rst_write_data", bus.write_data, '0);
        chk("rst_rsp_valid",  bus.rsp_valid, 4'b0000);
        chk("rst_rsp_data",   bus.rsp_data, '0);
        chk("rst_rd_out",     bus.rd_outstanding, 5'd0);
        chk("rst_err",        bus.err_unexpected_rdata, 1'b0);
        chk("rst_req_ready",  bus.req_ready, 4'b0000);
        rst_n = 1'b1;
        #1;

        // Single write: row 5, col 8, bank 2
        c1 = mk_cmd(1'b0, 13'd5, 10'd8, 3'd2);
        set_req(0, 1'b1, c1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        #1;
        chk("wr_req_ready", bus.req_ready, 4'b0001);
        step();
        set_req(0, 1'b0, c1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        #1;
        chk("wr_valid",      bus.valid, 1'b1);
        chk("wr_rw",         bus.command[31], 1'b0);
        chk("wr_bank",       bus.command[2:0], 3'd2);
        chk("wr_command",    bus.command, c1);
        chk("wr_data",       bus.write_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        chk("wr_rd_out",     bus.rd_outstanding, 5'd0);
        chk("wr_ready_drop", bus.req_ready, 4'b0000);
        step();
        chk("wr_idle_valid", bus.valid, 1'b0);
        chk("wr_idle_cmd",   bus.command, 34'd0);
        chk("wr_data_hold",  bus.write_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);

        // Round-robin fairness: all four write to bank 0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_cmd[i] = mk_cmd(1'b0, 13'(i + 1), 10'(16 * i), 3'd0);
            rr_wd[i]  = 128'hA000 + 128'(i);
            set_req(i, 1'b1, rr_cmd[i], rr_wd[i]);
        end
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << (n % NUM_REQ);
            #1;
            chk("rr_grant", bus.req_ready, oh);
            step();
            chk("rr_valid", bus.valid, 1'b1);
            chk("rr_cmd",   bus.command, rr_cmd[n % NUM_REQ]);
            chk("rr_wdata", bus.write_data, rr_wd[n % NUM_REQ]);
        end
        clear_inputs();

        // Permit blocking: req1 -> bank 3, req2 -> bank 1
        c1 = mk_cmd(1'b0, 13'd7, 10'd1, 3'd3);
        c2 = mk_cmd(1'b0, 13'd9, 10'd2, 3'd1);
        set_req(1, 1'b1, c1, 128'hB1);
        set_req(2, 1'b1, c2, 128'hB2);
        bus.ba_cmd_pm = 8'h02;
        #1;
        chk("pm_grant_r2", bus.req_ready, 4'b0100);
        step();
        chk("pm_cmd_r2", bus.command, c2);
        set_req(2, 1'b0, c2, 128'hB2);
        bus.ba_cmd_pm = 8'h08;
        #1;
        chk("pm_grant_r1", bus.req_ready, 4'b0010);
        step();
        chk("pm_cmd_r1",  bus.command, c1);
        chk("pm_data_r1", bus.write_data, 128'hB1);
        set_req(1, 1'b0, c1, 128'hB1);
        step();
        chk("pm_idle", bus.valid, 1'b0);

        // Read routing: reads from 3, 0, 2; beats A, B, C
        do_reset();
        rd_req[0] = 3; rd_req[1] = 0; rd_req[2] = 2;
        rd_beat[0] = 128'hA; rd_beat[1] = 128'hB; rd_beat[2] = 128'hC;
        for (int k = 0; k < 3; k++) begin
            c1 = mk_cmd(1'b1, 13'(k), 10'(k), 3'(k));
            set_req(rd_req[k], 1'b1, c1, 128'hDEAD);
            oh = 4'b0001 << rd_req[k];
            #1;
            chk("rd_grant", bus.req_ready, oh);
            step();
            set_req(rd_req[k], 1'b0, c1, 128'hDEAD);
            chk("rd_rw",     bus.command[31], 1'b1);
            chk("rd_wdata0", bus.write_data, '0);
            chk("rd_out_up", bus.rd_outstanding, 5'(k + 1));
        end
        for (int k = 0; k < 3; k++) begin
            bus.read_data       = rd_beat[k];
            bus.read_data_valid = 1'b1;
            oh = 4'b0001 << rd_req[k];
            step();
            chk("rsp_valid",   bus.rsp_valid, oh);
            chk("rsp_data",    bus.rsp_data, rd_beat[k]);
            chk("rd_out_down", bus.rd_outstanding, 5'(2 - k));
        end
        bus.read_data_valid = 1'b0;
        step();
        chk("rsp_idle", bus.rsp_valid, 4'b0000);

        // Full tag FIFO: 16 reads from requester 0
        do_reset();
        c1 = mk_cmd(1'b1, 13'd3, 10'd4, 3'd0);
        set_req(0, 1'b1, c1, '0);
        repeat (TAG_DEPTH) step();
        chk("full_rd_out", bus.rd_outstanding, 5'd16);
        #1;
        chk("full_rd_stall", bus.req_ready, 4'b0000);
        c2 = mk_cmd(1'b0, 13'd6, 10'd5, 3'd4);
        set_req(1, 1'b1, c2, 128'hC0FFEE);
        #1;
        chk("full_wr_grant", bus.req_ready, 4'b0010);
        step();
        set_req(1, 1'b0, c2, 128'hC0FFEE);
        chk("full_wr_issue", bus.command, c2);
        chk("full_wr_data",  bus.write_data, 128'hC0FFEE);
        chk("full_rd_out2",  bus.rd_outstanding, 5'd16);
        bus.read_data       = 128'h5A5A;
        bus.read_data_valid = 1'b1;
        #1;
        chk("full_pop_same_cycle", bus.req_ready, 4'b0000);
        step();
        bus.read_data_valid = 1'b0;
        chk("full_pop_rd_out", bus.rd_outstanding, 5'd15);
        chk("full_pop_rsp",    bus.rsp_valid, 4'b0001);
        chk("full_pop_data",   bus.rsp_data, 128'h5A5A);
        chk("full_pop_idle",   bus.valid, 1'b0);
        #1;
        chk("full_rd_resume", bus.req_ready, 4'b0001);
        step();
        set_req(0, 1'b0, c1, '0);
        chk("full_rd_issue", bus.command, c1);
        chk("full_rd_out3",  bus.rd_outstanding, 5'd16);

        // Unexpected read data, then reset mid-burst
        do_reset();
        bus.read_data       = 128'h77;
        bus.read_data_valid = 1'b1;
        step();
        bus.read_data_valid = 1'b0;
        chk("unexp_err",    bus.err_unexpected_rdata, 1'b1);
        chk("unexp_rsp",    bus.rsp_valid, 4'b0000);
        chk("unexp_rd_out", bus.rd_outstanding, 5'd0);
        step();
        chk("unexp_sticky", bus.err_unexpected_rdata, 1'b1);
        c1 = mk_cmd(1'b1, 13'd1, 10'd1, 3'd5);
        set_req(2, 1'b1, c1, '0);
        step();
        set_req(2, 1'b0, c1, '0);
        chk("burst_rd_out", bus.rd_outstanding, 5'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
            set_req(i, 1'b1, mk_cmd(1'b0, 13'd2, 10'(i), 3'd6), 128'hE0 + 128'(i));
        end
        step();
        step();
        chk("burst_valid", bus.valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid",      bus.valid, 1'b0);
        chk("mrst_command",    bus.command, 34'd0);
        chk("mrst_write_data", bus.write_data, '0);
        chk("mrst_rsp_valid",  bus.rsp_valid, 4'b0000);
        chk("mrst_rsp_data",   bus.rsp_data, '0);
        chk("mrst_rd_out",     bus.rd_outstanding, 5'd0);
        chk("mrst_err",        bus.err_unexpected_rdata, 1'b0);
        chk("mrst_req_ready",  bus.req_ready, 4'b0000);
        clear_inputs();
        step();
        rst_n = 1'b1;
        #1;
        bus.read_data       = 128'h99;
        bus.read_data_valid = 1'b1;
        step();
        bus.read_data_valid = 1'b0;
        chk("post_rst_err", bus.err_unexpected_rdata, 1'b1);
        chk("post_rst_rsp", bus.rsp_valid, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
